// File: rtl/gpu_pc_stack_if.sv
// Command/status bundle for the GPU program counter with return-address stack.
// The tri-state data bus stays a plain port on the design.
interface gpu_pc_stack_if #(
  parameter int PC_W  = 13,
  parameter int INC_W = 8,
  parameter int DEPTH = 4
);
  localparam int SP_W = $clog2(DEPTH + 1);

  logic [PC_W-1:0]  counter_input;
  logic [INC_W-1:0] increment_amount;
  logic             set_pc;
  logic             inc_pc;
  logic             rel_pc;
  logic             call_pc;
  logic             ret_pc;
  logic             read_pc;
  logic             clr_err;
  logic [PC_W-1:0]  pc;
  logic [SP_W-1:0]  sp;
  logic             overflow;
  logic             underflow;

  modport master (
    output counter_input, increment_amount, set_pc, inc_pc, rel_pc,
           call_pc, ret_pc, read_pc, clr_err,
    input  pc, sp, overflow, underflow
  );

  modport slave (
    input  counter_input, increment_amount, set_pc, inc_pc, rel_pc,
           call_pc, ret_pc, read_pc, clr_err,
    output pc, sp, overflow, underflow
  );
endinterface

// File: rtl/gpu_pc_stack.sv
// Program counter with absolute/relative jumps and a small call/return stack.
// One prioritised command per edge; sticky overflow/underflow flags.
module gpu_pc_stack #(
  parameter int PC_W  = 13,
  parameter int INC_W = 8,
  parameter int BUS_W = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  inout  wire [BUS_W-1:0]  bus,
  gpu_pc_stack_if.slave    cmd
);
  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(DEPTH);

  function automatic logic [PC_W-1:0] zext(input logic [INC_W-1:0] v);
    return PC_W'(v);
  endfunction

  function automatic logic [PC_W-1:0] sext(input logic signed [INC_W-1:0] v);
    logic signed [PC_W-1:0] w;
    w = PC_W'(v);
    return $unsigned(w);
  endfunction

  logic [PC_W-1:0]  pc_q;
  logic [SP_W-1:0]  sp_q;
  logic             ovf_q;
  logic             unf_q;
  logic [PC_W-1:0]  stack [DEPTH];

  logic             full;
  logic             empty;
  logic             do_call;
  logic             do_ret;
  logic             do_push;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic [PC_W-1:0]  ret_addr;

  // set_pc masks everything below it; call masks ret, and so on down.
  assign full     = (sp_q == SP_FULL);
  assign empty    = (sp_q == '0);
  assign do_call  = !cmd.set_pc && cmd.call_pc;
  assign do_ret   = !cmd.set_pc && !cmd.call_pc && cmd.ret_pc;
  assign do_push  = do_call && !full;
  assign wr_idx   = sp_q[IDX_W-1:0];
  assign rd_idx   = IDX_W'(sp_q - 1'b1);
  assign ret_addr = pc_q + zext(cmd.increment_amount);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= '0;
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (cmd.clr_err) begin
        ovf_q <= 1'b0;
        unf_q <= 1'b0;
      end
      if (cmd.set_pc) begin
        pc_q <= cmd.counter_input;
      end else if (cmd.call_pc) begin
        if (!full) begin
          pc_q <= cmd.counter_input;
          sp_q <= sp_q + 1'b1;
        end else begin
          ovf_q <= 1'b1;
        end
      end else if (cmd.ret_pc) begin
        if (!empty) begin
          pc_q <= stack[rd_idx];
          sp_q <= sp_q - 1'b1;
        end else begin
          unf_q <= 1'b1;
        end
      end else if (cmd.rel_pc) begin
        pc_q <= pc_q + sext(cmd.increment_amount);
      end else if (cmd.inc_pc) begin
        pc_q <= pc_q + zext(cmd.increment_amount);
      end
    end
  end

  // Stack storage is data only; stale entries above sp are never read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      stack[wr_idx] <= ret_addr;
    end
  end

  assign cmd.pc        = pc_q;
  assign cmd.sp        = sp_q;
  assign cmd.overflow  = ovf_q;
  assign cmd.underflow = unf_q;

  assign bus = cmd.read_pc ? BUS_W'(pc_q) : {BUS_W{1'bz}};

  logic unused_ok;
  assign unused_ok = do_ret;
endmodule

// File: doc/gpu_pc_stack.md
GPU_PC_STACK -- requirements
Module: gpu_pc_stack

Interface
REQ-001 Parameter PC_W, default 13: program counter width in bits.
REQ-002 Parameter INC_W, default 8: width of the increment/offset field.
REQ-003 Parameter BUS_W, default 16: shared data bus width, with BUS_W >= PC_W.
REQ-004 Parameter DEPTH, default 4: number of return-address stack entries, with DEPTH >= 2.
REQ-005 One clock; reset is asynchronous and active-high. Ports are clk and reset.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 bus  inout  BUS_W  shared tri-state bus.
REQ-009 counter_input  input  PC_W  absolute jump or call target.
REQ-010 increment_amount  input  INC_W  unsigned step, or signed offset when rel_pc is high.
REQ-011 set_pc  input  1  load counter_input.
REQ-012 inc_pc  input  1  advance counter by increment_amount, zero-extended.
REQ-013 rel_pc  input  1  relative branch: add increment_amount, sign-extended.
REQ-014 call_pc  input  1  push return address, then jump to counter_input.
REQ-015 ret_pc  input  1  pop top of stack into counter.
REQ-016 read_pc  input  1  drive counter onto bus.
REQ-017 clr_err  input  1  clear sticky error flags.
REQ-018 pc  output  PC_W  current counter value.
REQ-019 sp  output  $clog2(DEPTH+1)  current stack occupancy, 0..DEPTH.
REQ-020 overflow  output  1  sticky flag: call attempted while the stack was full.
REQ-021 underflow  output  1  sticky flag: return attempted while the stack was empty.

Function
REQ-022 When read_pc=1, bus SHALL be driven with the counter zero-extended to BUS_W; otherwise bus SHALL be high-Z. This path is combinational, same cycle.
REQ-023 Only one command acts per rising edge. Priority: set_pc > call_pc > ret_pc > rel_pc > inc_pc. Lower-priority commands in the same cycle are ignored.
REQ-024 set_pc: counter SHALL become counter_input. The stack is unchanged.
REQ-025 inc_pc: counter SHALL become counter + zero-extended increment_amount, modulo 2^PC_W.
REQ-026 rel_pc: counter SHALL become counter + sign-extended increment_amount, modulo 2^PC_W. Wrap-around is permitted in both directions.
REQ-027 call_pc with sp<DEPTH: push (counter + zero-extended increment_amount) mod 2^PC_W at index sp, sp+1, and counter becomes counter_input, all in one cycle.
REQ-028 call_pc with sp==DEPTH: no push, counter unchanged, sp unchanged, overflow set.
REQ-029 ret_pc with sp>0: counter becomes entry[sp-1], and sp decrements.
REQ-030 ret_pc with sp==0: counter unchanged, underflow set.
REQ-031 When no command is asserted, counter and stack SHALL hold.
REQ-032 clr_err clears overflow and underflow on the next edge. If an error event occurs in the same cycle, the set wins.
REQ-033 pc and sp reflect registered state, so a command's update is visible the cycle after its edge.
REQ-034 Stack entries are PC_W wide. Entries at index >= sp are don't-care and are never observable.

Reset
REQ-035 While reset=1, counter, sp, overflow and underflow SHALL be 0 immediately, independent of clk. Stack contents need not be cleared.
REQ-036 Reset asserted mid-sequence aborts any in-flight command. After release, the first return SHALL underflow.
REQ-037 bus tri-state control is unaffected by reset: read_pc during reset drives 0.

Verification
REQ-038 Reset, then read_pc=1 -> bus=16'h0000; read_pc=0 -> bus=Z.
REQ-039 inc_pc with counter=13'h1FFE, increment_amount=8'h05 -> pc=13'h0003 (wrap). Then rel_pc with increment_amount=8'hFC -> pc=13'h1FFF.
REQ-040 At pc=0x0010, call_pc with counter_input=0x0400 and increment_amount=2 -> pc=0x0400, sp=1. Then ret_pc -> pc=0x0012, sp=0.
REQ-041 Nested calls to fill DEPTH=4 (sp=4); a fifth call -> pc unchanged, sp=4, overflow=1. Four returns restore targets in LIFO order. A fifth return -> underflow=1. clr_err -> both flags 0.
REQ-042 set_pc, call_pc and inc_pc asserted together with counter_input=0x0AAA -> pc=0x0AAA and sp unchanged. Reset pulsed between clock edges at sp=3 -> pc=0 and sp=0 asynchronously.
